det_sched: RTL and testbench

DET_SCHED -- requirements
Module: det_sched

---
 rtl/det_sched_pkg.sv | 16 +
 rtl/det_sched_rr_arbiter.sv | 31 +++
 rtl/det_sched.sv | 119 +++++++++++
 tb/tb_det_sched.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/det_sched_pkg.sv
// Shared types and default sizing for the detector scheduler.
package det_sched_pkg;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_W       = 8;
  localparam int DEF_DET_LAT = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    RESP  = 3'd4
  } state_t;

endpackage

// File: rtl/det_sched_rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index,
  output logic          any
);

  logic [IW-1:0] cand;

  // Scan from ptr upward modulo N; the first hit wins.
  always_comb begin
    grant = '0;
    index = '0;
    any   = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = IW'((int'(ptr) + i) % N);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        index       = cand;
      end
    end
  end

endmodule

// File: rtl/det_sched.sv
// Serialises one requester word at a time through a shared bit-serial
// detector and returns the per-bit detector response.
//
//   state | meaning
//   IDLE  | waiting for a request; grant is combinational here
//   CLEAR | one cycle of det_clr to wipe detector history
//   SHIFT | W cycles presenting the word MSB first
//   DRAIN | DET_LAT cycles collecting the tail of det_y
//   RESP  | result held until the consumer accepts it
module det_sched
  import det_sched_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int W       = DEF_W,
  parameter int DET_LAT = DEF_DET_LAT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*W-1:0]       req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     det_clr,
  output logic                     det_en,
  output logic                     det_x,
  input  logic                     det_y,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [$clog2(N_REQ)-1:0] resp_id,
  output logic [W-1:0]             resp_mask,
  output logic                     resp_hit
);

  localparam int IW  = $clog2(N_REQ);
  localparam int TOT = W + DET_LAT;
  localparam int CW  = $clog2(TOT + 1);

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] id_q;
  logic [W-1:0]  shreg;
  logic [W-1:0]  mask_q;
  // Counts down over SHIFT+DRAIN; a value below W names the mask bit
  // whose det_y sample arrives this cycle.
  logic [CW-1:0] rem;

  logic [N_REQ-1:0] arb_grant;
  logic [IW-1:0]    arb_idx;
  logic             arb_any;
  logic             take;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .index (arb_idx),
    .any   (arb_any)
  );

  assign take      = (state == IDLE) && !rst && arb_any;
  assign req_ready = take ? arb_grant : '0;

  // Output decode from registered state; reset overrides everything.
  assign det_clr    = rst || (state == CLEAR);
  assign det_en     = !rst && (state == SHIFT);
  assign det_x      = det_en && shreg[W-1];
  assign resp_valid = !rst && (state == RESP);
  assign resp_id    = rst ? '0 : id_q;
  assign resp_mask  = rst ? '0 : mask_q;
  assign resp_hit   = |resp_mask;

  // Sequencer: grant, clear, shift out, collect det_y, hold result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      id_q   <= '0;
      shreg  <= '0;
      mask_q <= '0;
      rem    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            shreg  <= req_data[int'(arb_idx) * W +: W];
            id_q   <= arb_idx;
            mask_q <= '0;
            rr_ptr <= (int'(arb_idx) == N_REQ - 1) ? '0 : arb_idx + 1'b1;
            state  <= CLEAR;
          end
        end
        CLEAR: begin
          mask_q <= '0;
          rem    <= CW'(TOT - 1);
          state  <= SHIFT;
        end
        SHIFT, DRAIN: begin
          for (int k = 0; k < W; k++) begin
            if (rem == CW'(k)) mask_q[k] <= det_y;
          end
          rem <= rem - 1'b1;
          if (state == SHIFT) begin
            shreg <= shreg << 1;
            if (rem == CW'(DET_LAT)) state <= (DET_LAT == 0) ? RESP : DRAIN;
          end else if (rem == '0) begin
            state <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_det_sched.sv
// Randomised and directed bench for det_sched with a transaction-level
// reference model and an echoing single-cycle detector.
module tb_det_sched;
  import det_sched_pkg::*;

  localparam int N  = DEF_N_REQ;
  localparam int W  = DEF_W;
  localparam int L  = DEF_DET_LAT;
  localparam int IW = $clog2(N);

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           det_clr, det_en, det_x, det_y;
  logic           resp_valid, resp_ready;
  logic [IW-1:0]  resp_id;
  logic [W-1:0]   resp_mask;
  logic           resp_hit;

  always #5 clk = ~clk;

  det_sched #(.N_REQ(N), .W(W), .DET_LAT(L)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .det_clr    (det_clr),
    .det_en     (det_en),
    .det_x      (det_x),
    .det_y      (det_y),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_mask  (resp_mask),
    .resp_hit   (resp_hit)
  );

  int nvec = 0;
  int nerr = 0;

  // reference model: one transaction in flight, timed from its grant
  bit           m_busy = 1'b0;
  int           m_ph, m_ptr = 0, m_id;
  logic [W-1:0] m_word;
  int           gq[$];
  int           rq_id[$];
  logic [W-1:0] rq_mask[$];

  logic [N-1:0] s_rdy;
  logic         s_rv, s_en, s_x;
  logic         nxt_y;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [N-1:0] er;
    int gi;
    bit en, rv;
    s_rdy = req_ready;
    s_rv  = resp_valid;
    s_en  = det_en;
    s_x   = det_x;
    if (rst) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_det_clr", det_clr, 1);
      chk("rst_det_en", det_en, 0);
      chk("rst_det_x", det_x, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_id", resp_id, 0);
      chk("rst_resp_mask", resp_mask, 0);
      chk("rst_resp_hit", resp_hit, 0);
      m_busy = 1'b0;
      m_ptr  = 0;
    end else if (!m_busy) begin
      er = '0;
      gi = -1;
      for (int i = 0; i < N; i++) begin
        int c;
        c = (m_ptr + i) % N;
        if (gi < 0 && req_valid[c]) gi = c;
      end
      if (gi >= 0) begin
        er[gi] = 1'b1;
        m_busy = 1'b1;
        m_ph   = 0;
        m_id   = gi;
        m_word = req_data[gi*W +: W];
        m_ptr  = (gi + 1) % N;
        gq.push_back(gi);
      end
      chk("idle_req_ready", req_ready, er);
      chk("idle_det_clr", det_clr, 0);
      chk("idle_det_en", det_en, 0);
      chk("idle_det_x", det_x, 0);
      chk("idle_resp_valid", resp_valid, 0);
    end else begin
      m_ph++;
      en = (m_ph >= 2) && (m_ph <= W + 1);
      rv = (m_ph >= 2 + W + L);
      chk("busy_req_ready", req_ready, 0);
      chk("det_clr", det_clr, m_ph == 1);
      chk("det_en", det_en, en);
      if (en) chk("det_x", det_x, m_word[W-1-(m_ph-2)]);
      else    chk("det_x_idle", det_x, 0);
      chk("resp_valid", resp_valid, rv);
      if (rv) begin
        chk("resp_id", resp_id, m_id);
        chk("resp_mask", resp_mask, m_word);
        chk("resp_hit", resp_hit, |m_word);
        if (resp_ready) begin
          m_busy = 1'b0;
          rq_id.push_back(int'(resp_id));
          rq_mask.push_back(resp_mask);
        end
      end
    end
  endtask

  // one clock: check at negedge, then drive the echoed det_y after posedge
  task automatic cyc();
    @(negedge clk);
    model_step();
    nxt_y = det_en ? det_x : 1'($urandom);
    @(posedge clk);
    #1;
    det_y = nxt_y;
  endtask

  task automatic wait_grant(input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      cyc();
      if (s_rdy != 0) got = 1'b1;
    end
    if (!got) chk({tag, "_grant_timeout"}, 0, 1);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && m_busy; i++) cyc();
    if (m_busy) chk({tag, "_drain_timeout"}, 0, 1);
  endtask

  initial begin
    logic [W-1:0] xbits;
    int nx, lat, nrv, base;
    bit seen;

    rst = 1'b1; req_valid = '0; req_data = '0; resp_ready = 1'b1; det_y = 1'b0;
    repeat (2) cyc();
    rst = 1'b0;
    repeat (2) cyc();

    // single request, word A5
    req_valid = 4'b0001;
    req_data  = {24'h5A3C96, 8'hA5};
    wait_grant("single");
    chk("single_ready", s_rdy, 4'b0001);
    req_valid = '0;
    xbits = '0; nx = 0; lat = 0; seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      cyc();
      lat++;
      if (s_en) begin xbits = {xbits[W-2:0], s_x}; nx++; end
      if (s_rv) seen = 1'b1;
    end
    chk("single_seen", seen, 1);
    chk("single_latency", lat, 2 + W + L);
    chk("single_nbits", nx, W);
    chk("single_xseq", xbits, 8'hA5);
    chk("single_rid", rq_id[$], 0);
    chk("single_rmask", rq_mask[$], 8'hA5);

    // all four continuously valid from a fresh pointer
    rst = 1'b1; cyc(); rst = 1'b0;
    gq.delete(); rq_id.delete(); rq_mask.delete();
    req_valid = 4'hF;
    req_data  = 32'h33221100;
    for (int i = 0; i < 120 && gq.size() < 5; i++) cyc();
    req_valid = '0;
    drain("rr");
    chk("rr_ngrants", gq.size(), 5);
    if (gq.size() >= 5) begin
      chk("rr_g0", gq[0], 0);
      chk("rr_g1", gq[1], 1);
      chk("rr_g2", gq[2], 2);
      chk("rr_g3", gq[3], 3);
      chk("rr_g4", gq[4], 0);
    end
    if (rq_mask.size() >= 4) begin
      chk("rr_m0", rq_mask[0], 8'h00);
      chk("rr_m1", rq_mask[1], 8'h11);
      chk("rr_m2", rq_mask[2], 8'h22);
      chk("rr_m3", rq_mask[3], 8'h33);
    end else chk("rr_nresp", rq_mask.size(), 5);

    // backpressure: five refused RESP cycles, accept on the sixth
    resp_ready = 1'b0;
    req_valid  = 4'b0010;
    req_data   = {$urandom, 32'h0};
    req_data[W +: W] = 8'h6C;
    wait_grant("bp");
    req_valid = 4'b1101;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      cyc();
      if (s_rv) seen = 1'b1;
    end
    chk("bp_seen", seen, 1);
    nrv = 1;
    repeat (4) begin
      cyc();
      if (s_rv) nrv++;
      chk("bp_no_ready", s_rdy, 0);
    end
    chk("bp_hold_cycles", nrv, 5);
    req_valid  = '0;
    resp_ready = 1'b1;
    cyc();
    chk("bp_accept_rv", s_rv, 1);
    cyc();
    chk("bp_idle_rv", s_rv, 0);
    chk("bp_rmask", rq_mask[$], 8'h6C);

    // reset while bit 4 is on the wire
    rst = 1'b1; cyc(); rst = 1'b0;
    req_valid = 4'b0100;
    req_data  = {$urandom};
    wait_grant("rstmid");
    chk("rstmid_gid", gq[$], 2);
    req_valid = 4'b1001;
    base = rq_id.size();
    repeat (5) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    chk("rstmid_next_gid", gq[$], 0);
    chk("rstmid_next_rdy", s_rdy, 4'b0001);
    req_valid = '0;
    drain("rstmid");
    chk("rstmid_nresp", rq_id.size() - base, 1);

    // short pulse from requester 2 while busy must be dropped
    base = rq_id.size();
    req_valid = 4'b0001;
    wait_grant("pulse");
    req_valid = '0;
    repeat (4) cyc();
    req_valid = 4'b0100;
    cyc();
    req_valid = '0;
    drain("pulse");
    repeat (3) cyc();
    nx = 0;
    for (int i = base; i < rq_id.size(); i++) if (rq_id[i] == 2) nx++;
    chk("pulse_no_id2", nx, 0);
    chk("pulse_nresp", rq_id.size() - base, 1);

    // randomised traffic with occasional reset
    for (int i = 0; i < 2500; i++) begin
      req_valid  = N'($urandom);
      req_data   = {$urandom};
      resp_ready = ($urandom_range(0, 3) != 0);
      rst        = ($urandom_range(0, 199) == 0);
      cyc();
    end
    rst = 1'b0; req_valid = '0; resp_ready = 1'b1;
    drain("rand");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
